dmem_arbiter: RTL and testbench

- Sits between the CPU datapath, the host configuration port and the 32-word data memory.
- Shares the memory's single access port between the two requesters, one access per clock.
- Keeps frame-stable shadow copies of the fractal pan parameters (words 31 and 30) for the fractal core. The shadows update only on a frame boundary, so pans written mid-frame never tear an image.

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU and the host.
// Also holds frame-stable shadow copies of the pan words for the fractal core.
module dmem_arbiter #(
   parameter int         HOST_BURST_MAX = 4,
   parameter logic [4:0] PANX_WORD      = 5'd31,
   parameter logic [4:0] PANY_WORD      = 5'd30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [12:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [12:0] host_addr,
   input  logic [31:0] host_wdata,
   output logic        host_ack,
   output logic [31:0] host_rdata,
   output logic [12:0] mem_addr,
   output logic [31:0] mem_writedata,
   output logic        mem_memwrite,
   input  logic [31:0] mem_readdata,
   input  logic [31:0] mem_panx,
   input  logic [31:0] mem_pany,
   input  logic        frame_start,
   output logic [31:0] fc_panx,
   output logic [31:0] fc_pany,
   output logic        fc_params_valid
);

   typedef enum logic {P_IDLE, P_PEND} pload_t;

   localparam logic [3:0] BURST_MAX = 4'(HOST_BURST_MAX);

   logic        host_ack_reg;
   logic [31:0] host_rdata_reg;
   logic [3:0]  burst_reg, burst_next;
   pload_t      pstate_reg, pstate_next;
   logic [31:0] fc_panx_reg, fc_pany_reg;
   logic        fc_valid_reg;

   logic cpu_act, host_elig, cpu_gnt, host_gnt;
   logic pan_write, shadow_load;

   // Requests are ignored while reset is held so no write reaches memory.
   assign cpu_act   = rst_n & cpu_req;
   assign host_elig = rst_n & host_req & ~host_ack;
   assign cpu_gnt   = cpu_act & (~host_elig | (burst_reg == BURST_MAX));
   assign host_gnt  = host_elig & ~cpu_gnt;

   always_comb begin
      mem_addr      = 13'd0;
      mem_writedata = 32'd0;
      mem_memwrite  = 1'b0;
      cpu_rdata     = 32'd0;
      if (cpu_gnt) begin
         mem_addr      = cpu_addr;
         mem_writedata = cpu_wdata;
         mem_memwrite  = cpu_we;
         cpu_rdata     = mem_readdata;
      end else if (host_gnt) begin
         mem_addr      = host_addr;
         mem_writedata = host_wdata;
         mem_memwrite  = host_we;
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;

   always_comb begin
      burst_next = burst_reg;
      if (!cpu_req || cpu_gnt)
         burst_next = 4'd0;
      else if (host_gnt && (burst_reg != BURST_MAX))
         burst_next = burst_reg + 4'd1;
   end

   // Only the low five address bits select a memory word.
   assign pan_write = mem_memwrite &
                      ((mem_addr[4:0] == PANX_WORD) || (mem_addr[4:0] == PANY_WORD));

   always_comb begin
      pstate_next = pstate_reg;
      shadow_load = 1'b0;
      case (pstate_reg)
         P_IDLE: begin
            if (frame_start) begin
               if (pan_write)
                  pstate_next = P_PEND;
               else
                  shadow_load = 1'b1;
            end
         end
         P_PEND: begin
            if (!pan_write) begin
               shadow_load = 1'b1;
               pstate_next = P_IDLE;
            end
         end
         default: pstate_next = P_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_ack_reg   <= 1'b0;
         host_rdata_reg <= 32'd0;
         burst_reg      <= 4'd0;
         pstate_reg     <= P_IDLE;
         fc_panx_reg    <= 32'd0;
         fc_pany_reg    <= 32'd0;
         fc_valid_reg   <= 1'b0;
      end else begin
         host_ack_reg <= host_gnt;
         if (host_gnt && !host_we)
            host_rdata_reg <= mem_readdata;
         burst_reg  <= burst_next;
         pstate_reg <= pstate_next;
         if (shadow_load) begin
            fc_panx_reg  <= mem_panx;
            fc_pany_reg  <= mem_pany;
            fc_valid_reg <= 1'b1;
         end
      end
   end

   assign host_ack        = host_ack_reg;
   assign host_rdata      = host_rdata_reg;
   assign fc_panx         = fc_panx_reg;
   assign fc_pany         = fc_pany_reg;
   assign fc_params_valid = fc_valid_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle vector table plus burst and reset sequences.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, host_req, host_we, frame_start;
   logic [12:0] cpu_addr, host_addr;
   logic [31:0] cpu_wdata, host_wdata;
   logic [31:0] cpu_rdata, host_rdata, mem_writedata, mem_readdata;
   logic [31:0] mem_panx, mem_pany, fc_panx, fc_pany;
   logic [12:0] mem_addr;
   logic        cpu_stall, host_ack, mem_memwrite, fc_params_valid;

   int tests = 0;
   int fails = 0;

   logic [31:0] mem_model [32];
   logic        mem_load;

   always #5 clk = ~clk;

   dmem_arbiter #(.HOST_BURST_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata),
      .mem_addr(mem_addr), .mem_writedata(mem_writedata), .mem_memwrite(mem_memwrite),
      .mem_readdata(mem_readdata), .mem_panx(mem_panx), .mem_pany(mem_pany),
      .frame_start(frame_start), .fc_panx(fc_panx), .fc_pany(fc_pany),
      .fc_params_valid(fc_params_valid)
   );

   // Memory: asynchronous read, write at the rising edge.
   assign mem_readdata = mem_model[mem_addr[4:0]];
   assign mem_panx     = mem_model[31];
   assign mem_pany     = mem_model[30];

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 30; i++) mem_model[i] <= 32'h100 + 32'(i);
         mem_model[30] <= 32'hFFFFF000;
         mem_model[31] <= 32'h00001000;
      end else if (mem_memwrite) begin
         mem_model[mem_addr[4:0]] <= mem_writedata;
      end
   end

   typedef struct {
      logic        cr, cw;
      logic [12:0] ca;
      logic [31:0] cd;
      logic        hr, hw;
      logic [12:0] ha;
      logic [31:0] hd;
      logic        fs;
      logic [12:0] e_addr;
      logic        e_we;
      logic [31:0] e_wd;
      logic        e_stall;
      logic [31:0] e_crd;
      logic        e_hack;
      logic [31:0] e_hrd, e_px, e_py;
      logic        e_val;
   } vec_t;

   vec_t vecs [20];

   function automatic vec_t mk(
      input logic cr, input logic cw, input logic [12:0] ca, input logic [31:0] cd,
      input logic hr, input logic hw, input logic [12:0] ha, input logic [31:0] hd,
      input logic fs,
      input logic [12:0] e_addr, input logic e_we, input logic [31:0] e_wd,
      input logic e_stall, input logic [31:0] e_crd, input logic e_hack,
      input logic [31:0] e_hrd, input logic [31:0] e_px, input logic [31:0] e_py,
      input logic e_val);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd; v.fs = fs;
      v.e_addr = e_addr; v.e_we = e_we; v.e_wd = e_wd; v.e_stall = e_stall;
      v.e_crd = e_crd; v.e_hack = e_hack; v.e_hrd = e_hrd;
      v.e_px = e_px; v.e_py = e_py; v.e_val = e_val;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      frame_start = 0;
   endtask

   int stall_cnt;

   initial begin
      // Pan words 31 = 0x1000, 30 = 0xFFFFF000; word i = 0x100 + i otherwise.
      //           cr cw ca       cd            hr hw ha     hd            fs  addr     we wd            st crd           ak hrd           px            py            val
      vecs[0]  = mk(0, 0, 13'd0,  32'h0,        0, 0, 13'd0, 32'h0,        1,  13'd0,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0);
      vecs[1]  = mk(1, 1, 13'd3,  32'hDEADBEEF, 0, 0, 13'd0, 32'h0,        0,  13'd3,   1, 32'hDEADBEEF, 0, 32'h103,      0, 32'h0,        32'h1000,     32'hFFFFF000, 1);
      vecs[2]  = mk(1, 0, 13'd3,  32'h0,        0, 0, 13'd0, 32'h0,        0,  13'd3,   0, 32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        32'h1000,     32'hFFFFF000, 1);
      vecs[3]  = mk(0, 0, 13'd0,  32'h0,        1, 0, 13'd31,32'h0,        0,  13'd31,  0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h1000,     32'hFFFFF000, 1);
      vecs[4]  = mk(0, 0, 13'd0,  32'h0,        1, 0, 13'd31,32'h0,        0,  13'd0,   0, 32'h0,        0, 32'h0,        1, 32'h1000,     32'h1000,     32'hFFFFF000, 1);
      vecs[5]  = mk(0, 0, 13'd0,  32'h0,        1, 0, 13'd31,32'h0,        0,  13'd31,  0, 32'h0,        0, 32'h0,        0, 32'h1000,     32'h1000,     32'hFFFFF000, 1);
      vecs[6]  = mk(0, 0, 13'd0,  32'h0,        0, 0, 13'd0, 32'h0,        0,  13'd0,   0, 32'h0,        0, 32'h0,        1, 32'h1000,     32'h1000,     32'hFFFFF000, 1);
      vecs[7]  = mk(1, 0, 13'd5,  32'h0,        1, 1, 13'd7, 32'hA5A5A5A5, 0,  13'd7,   1, 32'hA5A5A5A5, 1, 32'h0,        0, 32'h1000,     32'h1000,     32'hFFFFF000, 1);
      vecs[8]  = mk(1, 0, 13'd5,  32'h0,        1, 1, 13'd7, 32'hA5A5A5A5, 0,  13'd5,   0, 32'h0,        0, 32'h105,      1, 32'h1000,     32'h1000,     32'hFFFFF000, 1);
      vecs[9]  = mk(1, 0, 13'd7,  32'h0,        0, 0, 13'd0, 32'h0,        0,  13'd7,   0, 32'h0,        0, 32'hA5A5A5A5, 0, 32'h1000,     32'h1000,     32'hFFFFF000, 1);
      vecs[10] = mk(1, 1, 13'd31, 32'h2,        0, 0, 13'd0, 32'h0,        1,  13'd31,  1, 32'h2,        0, 32'h1000,     0, 32'h1000,     32'h1000,     32'hFFFFF000, 1);
      vecs[11] = mk(0, 0, 13'd0,  32'h0,        0, 0, 13'd0, 32'h0,        0,  13'd0,   0, 32'h0,        0, 32'h0,        0, 32'h1000,     32'h1000,     32'hFFFFF000, 1);
      vecs[12] = mk(1, 1, 13'h1FFF,32'h9,       0, 0, 13'd0, 32'h0,        0,  13'h1FFF,1, 32'h9,        0, 32'h2,        0, 32'h1000,     32'h2,        32'hFFFFF000, 1);
      vecs[13] = mk(0, 0, 13'd0,  32'h0,        0, 0, 13'd0, 32'h0,        0,  13'd0,   0, 32'h0,        0, 32'h0,        0, 32'h1000,     32'h2,        32'hFFFFF000, 1);
      vecs[14] = mk(0, 0, 13'd0,  32'h0,        0, 0, 13'd0, 32'h0,        1,  13'd0,   0, 32'h0,        0, 32'h0,        0, 32'h1000,     32'h2,        32'hFFFFF000, 1);
      vecs[15] = mk(0, 0, 13'd0,  32'h0,        0, 0, 13'd0, 32'h0,        0,  13'd0,   0, 32'h0,        0, 32'h0,        0, 32'h1000,     32'h9,        32'hFFFFF000, 1);
      vecs[16] = mk(1, 1, 13'd30, 32'h30,       0, 0, 13'd0, 32'h0,        1,  13'd30,  1, 32'h30,       0, 32'hFFFFF000, 0, 32'h1000,     32'h9,        32'hFFFFF000, 1);
      vecs[17] = mk(1, 1, 13'd31, 32'h31,       0, 0, 13'd0, 32'h0,        1,  13'd31,  1, 32'h31,       0, 32'h9,        0, 32'h1000,     32'h9,        32'hFFFFF000, 1);
      vecs[18] = mk(0, 0, 13'd0,  32'h0,        0, 0, 13'd0, 32'h0,        0,  13'd0,   0, 32'h0,        0, 32'h0,        0, 32'h1000,     32'h9,        32'hFFFFF000, 1);
      vecs[19] = mk(0, 0, 13'd0,  32'h0,        0, 0, 13'd0, 32'h0,        0,  13'd0,   0, 32'h0,        0, 32'h0,        0, 32'h1000,     32'h31,       32'h30,       1);

      idle_inputs();
      rst_n    = 1'b0;
      mem_load = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst host_ack",   32'(host_ack), 32'h0);
      chk("rst host_rdata", host_rdata, 32'h0);
      chk("rst fc_panx",    fc_panx, 32'h0);
      chk("rst fc_pany",    fc_pany, 32'h0);
      chk("rst valid",      32'(fc_params_valid), 32'h0);
      chk("rst memwrite",   32'(mem_memwrite), 32'h0);
      chk("rst mem_addr",   32'(mem_addr), 32'h0);
      rst_n    = 1'b1;
      mem_load = 1'b0;
      @(posedge clk);

      for (int i = 0; i < 20; i++) begin
         #1;
         cpu_req = vecs[i].cr; cpu_we = vecs[i].cw; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
         host_req = vecs[i].hr; host_we = vecs[i].hw; host_addr = vecs[i].ha; host_wdata = vecs[i].hd;
         frame_start = vecs[i].fs;
         #3;
         chk($sformatf("v%0d mem_addr", i),   32'(mem_addr), 32'(vecs[i].e_addr));
         chk($sformatf("v%0d memwrite", i),   32'(mem_memwrite), 32'(vecs[i].e_we));
         chk($sformatf("v%0d writedata", i),  mem_writedata, vecs[i].e_wd);
         chk($sformatf("v%0d cpu_stall", i),  32'(cpu_stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d cpu_rdata", i),  cpu_rdata, vecs[i].e_crd);
         chk($sformatf("v%0d host_ack", i),   32'(host_ack), 32'(vecs[i].e_hack));
         chk($sformatf("v%0d host_rdata", i), host_rdata, vecs[i].e_hrd);
         chk($sformatf("v%0d fc_panx", i),    fc_panx, vecs[i].e_px);
         chk($sformatf("v%0d fc_pany", i),    fc_pany, vecs[i].e_py);
         chk($sformatf("v%0d valid", i),      32'(fc_params_valid), 32'(vecs[i].e_val));
         @(posedge clk);
      end

      // Host made permanently eligible: expect H,H,H,H,C repeating.
      force dut.host_ack = 1'b0;
      stall_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         cpu_req = 1; cpu_we = 0; cpu_addr = 13'd2;
         host_req = 1; host_we = 0; host_addr = 13'd1;
         #3;
         chk($sformatf("burst%0d mem_addr", i), 32'(mem_addr), (i % 5 == 4) ? 32'd2 : 32'd1);
         chk($sformatf("burst%0d cpu_stall", i), 32'(cpu_stall), (i % 5 == 4) ? 32'd0 : 32'd1);
         if (cpu_stall) stall_cnt++;
         @(posedge clk);
      end
      chk("burst stall count", 32'(stall_cnt), 32'd8);
      release dut.host_ack;
      #1;
      idle_inputs();
      @(posedge clk);
      @(posedge clk);

      // Asynchronous reset while a host request is outstanding.
      #1;
      host_req = 1; host_we = 0; host_addr = 13'd4;
      @(posedge clk);
      #1;
      chk("pre-rst host_ack", 32'(host_ack), 32'h1);
      host_we = 1; host_addr = 13'd12; host_wdata = 32'h12345678;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst host_ack", 32'(host_ack), 32'h0);
      chk("arst fc_panx",  fc_panx, 32'h0);
      chk("arst fc_pany",  fc_pany, 32'h0);
      chk("arst valid",    32'(fc_params_valid), 32'h0);
      chk("arst memwrite", 32'(mem_memwrite), 32'h0);
      @(posedge clk);
      #1;
      chk("arst no write", mem_model[12], 32'h10C);
      rst_n = 1'b1;
      #2;
      chk("post-rst grant", 32'(mem_memwrite), 32'h1);
      @(posedge clk);
      #1;
      chk("post-rst ack",   32'(host_ack), 32'h1);
      chk("post-rst write", mem_model[12], 32'h12345678);
      idle_inputs();
      @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
